// File: rtl/daq_pkt_pkg.sv
// Shared types and constants for the DAQ packet receive path.
package daq_pkt_pkg;

    typedef enum logic [2:0] {
        S_HDR,
        S_TS,
        S_CNT,
        S_PAY,
        S_ERR,
        S_DISC
    } rx_state_t;

    typedef enum logic [1:0] {
        ERR_HDR    = 2'd0,
        ERR_TRUNC  = 2'd1,
        ERR_NOLAST = 2'd2
    } err_code_t;

    localparam int unsigned HDR_BYTES        = 4;
    localparam int unsigned TS_BYTES         = 4;
    localparam int unsigned BYTES_PER_SAMPLE = 4;
    localparam logic [31:0] DEFAULT_HEADER_MAGIC = 32'hA55A_C33C;

    // Header byte idx of magic, most significant byte first.
    function automatic logic [7:0] magic_byte(input logic [31:0] magic, input logic [1:0] idx);
        logic [31:0] shifted;
        shifted = magic >> {~idx, 3'b000};
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/daq_sample_assembler.sv
// Packs payload bytes into {ch0, ch1} beats behind a single output register;
// stall_o flags that the register is full and the consumer is not taking it.
module daq_sample_assembler
    import daq_pkt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    input  logic        last_beat_i,
    input  logic        flush_i,
    input  logic        smp_ready_i,
    output logic [15:0] smp_ch0_o,
    output logic [15:0] smp_ch1_o,
    output logic        smp_valid_o,
    output logic        smp_last_o,
    output logic        stall_o
);
    localparam logic [1:0] FILL_LAST = 2'(BYTES_PER_SAMPLE - 1);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  fill_q, fill_d;
    logic [15:0] ch0_q, ch0_d, ch1_q, ch1_d;
    logic        valid_q, valid_d, last_q, last_d;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        shift_d = shift_q;
        fill_d  = fill_q;
        ch0_d   = ch0_q;
        ch1_d   = ch1_q;
        valid_d = valid_q;
        last_d  = last_q;

        if (valid_q && smp_ready_i) begin
            valid_d = 1'b0;
        end

        if (flush_i) begin
            fill_d = '0;
        end else if (byte_valid_i) begin
            if (fill_q == FILL_LAST) begin
                ch0_d   = shift_q[23:8];
                ch1_d   = {shift_q[7:0], byte_i};
                valid_d = 1'b1;
                last_d  = last_beat_i;
                fill_d  = '0;
            end else begin
                shift_d = {shift_q[15:0], byte_i};
                fill_d  = fill_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            shift_q <= '0;
            fill_q  <= '0;
            ch0_q   <= '0;
            ch1_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            fill_q  <= fill_d;
            ch0_q   <= ch0_d;
            ch1_q   <= ch1_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign smp_ch0_o   = ch0_q;
    assign smp_ch1_o   = ch1_q;
    assign smp_valid_o = valid_q;
    assign smp_last_o  = last_q;
    assign stall_o     = valid_q && !smp_ready_i;

endmodule

// File: rtl/daq_packet_rx.sv
// Byte-stream decoder for DAQ capture packets: framing check, metadata, sample beats.
// Define DAQ_PACKET_RX_STATS_EN to add saturating stat_good/stat_bad packet counters.
module daq_packet_rx
    import daq_pkt_pkg::*;
#(
    parameter logic [31:0] HEADER_MAGIC = DEFAULT_HEADER_MAGIC,
    parameter int unsigned ERR_BYTES    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        rx_last,
    output logic [15:0] smp_ch0,
    output logic [15:0] smp_ch1,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic        smp_last,
    output logic [31:0] pkt_timestamp,
    output logic [7:0]  pkt_count,
    output logic [15:0] pkt_error_flags,
    output logic        pkt_done,
    output logic        pkt_err,
`ifdef DAQ_PACKET_RX_STATS_EN
    output logic [15:0] stat_good,
    output logic [15:0] stat_bad,
`endif
    output logic [1:0]  pkt_err_code
);
    localparam logic [9:0] HDR_LAST = 10'(HDR_BYTES - 1);
    localparam logic [9:0] TS_LAST  = 10'(TS_BYTES - 1);
    localparam logic [9:0] ERR_LAST = 10'(ERR_BYTES - 1);

    rx_state_t   state_q, state_d;
    logic [9:0]  idx_q, idx_d;
    logic [31:0] ts_q, ts_d;
    logic [7:0]  count_q, count_d;
    logic [15:0] stage_q, stage_d;
    logic [15:0] flags_q, flags_d;
    logic        done_q, done_d, err_q, err_d;
    err_code_t   code_q, code_d;

    logic       accept, trunc;
    logic       asm_byte_valid, asm_flush, asm_last_beat, asm_stall;
    logic [9:0] pay_last_idx;

    assign pay_last_idx  = 10'(count_q) * 10'(BYTES_PER_SAMPLE) - 10'd1;
    assign asm_last_beat = (idx_q[9:2] == count_q - 8'd1);
    // Only a full output register blocks input, and only while payload is flowing.
    assign rx_ready      = !((state_q == S_PAY) && asm_stall);
    assign accept        = rx_valid && rx_ready;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        ts_d           = ts_q;
        count_d        = count_q;
        stage_d        = (state_q == S_ERR) ? stage_q : '0;
        flags_d        = flags_q;
        code_d         = code_q;
        done_d         = 1'b0;
        err_d          = 1'b0;
        trunc          = 1'b0;
        asm_byte_valid = 1'b0;
        asm_flush      = 1'b0;

        if (accept) begin
            case (state_q)
                S_HDR: begin
                    if (rx_data != magic_byte(HEADER_MAGIC, idx_q[1:0])) begin
                        err_d   = 1'b1;
                        code_d  = ERR_HDR;
                        idx_d   = '0;
                        state_d = rx_last ? S_HDR : S_DISC;
                    end else if (rx_last) begin
                        trunc = 1'b1;
                    end else if (idx_q == HDR_LAST) begin
                        idx_d   = '0;
                        state_d = S_TS;
                    end else begin
                        idx_d = idx_q + 10'd1;
                    end
                end
                S_TS: begin
                    ts_d = {ts_q[23:0], rx_data};
                    if (rx_last) begin
                        trunc = 1'b1;
                    end else if (idx_q == TS_LAST) begin
                        idx_d   = '0;
                        state_d = S_CNT;
                    end else begin
                        idx_d = idx_q + 10'd1;
                    end
                end
                S_CNT: begin
                    count_d = rx_data;
                    idx_d   = '0;
                    if (rx_last) begin
                        trunc = 1'b1;
                    end else begin
                        state_d = (rx_data == 8'd0) ? S_ERR : S_PAY;
                    end
                end
                S_PAY: begin
                    // A byte carrying an early rx_last never completes a beat.
                    if (rx_last) begin
                        asm_flush = 1'b1;
                        trunc     = 1'b1;
                    end else begin
                        asm_byte_valid = 1'b1;
                        if (idx_q == pay_last_idx) begin
                            idx_d   = '0;
                            state_d = S_ERR;
                        end else begin
                            idx_d = idx_q + 10'd1;
                        end
                    end
                end
                S_ERR: begin
                    stage_d = {stage_q[7:0], rx_data};
                    if (idx_q == ERR_LAST) begin
                        idx_d = '0;
                        if (rx_last) begin
                            flags_d = stage_d;
                            done_d  = 1'b1;
                            state_d = S_HDR;
                        end else begin
                            err_d   = 1'b1;
                            code_d  = ERR_NOLAST;
                            state_d = S_DISC;
                        end
                    end else if (rx_last) begin
                        trunc = 1'b1;
                    end else begin
                        idx_d = idx_q + 10'd1;
                    end
                end
                S_DISC: begin
                    if (rx_last) begin
                        state_d = S_HDR;
                    end
                end
                default: state_d = S_HDR;
            endcase
        end

        if (trunc) begin
            err_d   = 1'b1;
            code_d  = ERR_TRUNC;
            idx_d   = '0;
            state_d = S_HDR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_HDR;
            idx_q   <= '0;
            ts_q    <= '0;
            count_q <= '0;
            stage_q <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_HDR;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ts_q    <= ts_d;
            count_q <= count_d;
            stage_q <= stage_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    daq_sample_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .byte_i       (rx_data),
        .byte_valid_i (asm_byte_valid),
        .last_beat_i  (asm_last_beat),
        .flush_i      (asm_flush),
        .smp_ready_i  (smp_ready),
        .smp_ch0_o    (smp_ch0),
        .smp_ch1_o    (smp_ch1),
        .smp_valid_o  (smp_valid),
        .smp_last_o   (smp_last),
        .stall_o      (asm_stall)
    );

    assign pkt_timestamp   = ts_q;
    assign pkt_count       = count_q;
    assign pkt_error_flags = flags_q;
    assign pkt_done        = done_q;
    assign pkt_err         = err_q;
    assign pkt_err_code    = code_q;

`ifdef DAQ_PACKET_RX_STATS_EN
    logic [15:0] good_q, bad_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            good_q <= '0;
            bad_q  <= '0;
        end else begin
            if (done_q && (good_q != 16'hFFFF)) good_q <= good_q + 16'd1;
            if (err_q && (bad_q != 16'hFFFF))   bad_q  <= bad_q + 16'd1;
        end
    end

    assign stat_good = good_q;
    assign stat_bad  = bad_q;
`endif

endmodule
